// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 control sequencer: opcodes, T-state encoding
// and the bit positions of the 13-bit control word.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Encoding doubles as the T-state index reported on uio_out[7:5].
  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6
  } tstate_e;

  localparam int CW_W    = 13;
  localparam int CW_CP   = 0;
  localparam int CW_EP   = 1;
  localparam int CW_LM   = 2;
  localparam int CW_CE   = 3;
  localparam int CW_LI   = 4;
  localparam int CW_EI   = 5;
  localparam int CW_LA   = 6;
  localparam int CW_EA   = 7;
  localparam int CW_SU   = 8;
  localparam int CW_EU   = 9;
  localparam int CW_LB   = 10;
  localparam int CW_LO   = 11;
  localparam int CW_HALT = 12;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/sap1_step_sync.sv
// Step-button synchronizer and rising-edge detector for single-step mode.
// Only compiled when SAP1_STEP_MODE_EN is defined.
`ifdef SAP1_STEP_MODE_EN
module sap1_step_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], step};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule
`endif

// File: rtl/tt_um_sap1_sequencer.sv
// SAP-1 control sequencer: T1..T6 ring plus HALT, decoding the latched opcode into
// the control word. Define SAP1_STEP_MODE_EN to enable single-step gating on ui_in[5:4].
module tt_um_sap1_sequencer
  import sap1_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EARLY_END   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  tstate_e    state_q, state_d;
  logic [3:0] op_q;
  logic       advance;
  cw_t        cw;
  logic       unused;

  assign unused = &{1'b0, uio_in, ena, ui_in[7:4], SYNC_STAGES[0]};

`ifdef SAP1_STEP_MODE_EN
  logic step_pulse;

  sap1_step_sync #(.STAGES(SYNC_STAGES)) u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (ui_in[5]),
    .pulse (step_pulse)
  );

  assign advance = !ui_in[4] || step_pulse;
`else
  assign advance = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_T1;
    else        state_q <= state_d;
  end

  // Opcode is captured on the T3->T4 edge so T4..T6 ignore later changes on ui_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           op_q <= OP_LDA;
    else if (advance && state_q == ST_T3) op_q <= ui_in[3:0];
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        ST_T1: state_d = ST_T2;
        ST_T2: state_d = ST_T3;
        ST_T3: state_d = ST_T4;
        ST_T4: begin
          if (op_q == OP_HLT)
            state_d = ST_HALT;
          else if (EARLY_END && op_q != OP_LDA && op_q != OP_ADD && op_q != OP_SUB)
            state_d = ST_T1;
          else
            state_d = ST_T5;
        end
        ST_T5: state_d = (EARLY_END && op_q == OP_LDA) ? ST_T1 : ST_T6;
        ST_T6: state_d = ST_T1;
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_comb begin
    cw = '0;
    case (state_q)
      ST_T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b1;
      end
      ST_T2: cw[CW_CP] = 1'b1;
      ST_T3: begin
        cw[CW_CE] = 1'b1;
        cw[CW_LI] = 1'b1;
      end
      ST_T4: begin
        case (op_q)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_EI] = 1'b1;
            cw[CW_LM] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_EA] = 1'b1;
            cw[CW_LO] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_q)
          OP_LDA: begin
            cw[CW_CE] = 1'b1;
            cw[CW_LA] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_CE] = 1'b1;
            cw[CW_LB] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          cw[CW_EU] = 1'b1;
          cw[CW_LA] = 1'b1;
          cw[CW_SU] = (op_q == OP_SUB);
        end
      end
      ST_HALT: cw[CW_HALT] = 1'b1;
      default: ;
    endcase
  end

  assign uo_out  = cw[7:0];
  assign uio_out = {state_q, cw[CW_HALT:CW_SU]};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_sap1_sequencer.sv
// Directed bench for tt_um_sap1_sequencer: table-driven per-cycle control words for
// both EARLY_END settings, plus hand sequences for HALT, mid-instruction reset and stepping.
module tb_tt_um_sap1_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in, ee_ui;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] ee_uo, ee_uio, ee_oe;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         ee;
    bit         rst;
    logic [7:0] ui;
    logic [7:0] uo;
    logic [7:0] uio;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  tt_um_sap1_sequencer #(.SYNC_STAGES(SYNC), .EARLY_END(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(8'h00), .uio_out(uio_out), .uio_oe(uio_oe), .ena(1'b1)
  );

  tt_um_sap1_sequencer #(.SYNC_STAGES(SYNC), .EARLY_END(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .ui_in(ee_ui), .uo_out(ee_uo),
    .uio_in(8'h00), .uio_out(ee_uio), .uio_oe(ee_oe), .ena(1'b1)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  // Bus drivers are EP, CE, EI, EA (uo) and EU (uio[1]); at most one may be high.
  function automatic logic [7:0] drivers_ok(input logic [7:0] uo, input logic [7:0] uio);
    logic [4:0] drv;
    drv = {uo[1], uo[3], uo[5], uo[7], uio[1]};
    return {7'd0, ($countones(drv) <= 1)};
  endfunction

  task automatic check_inv();
    check("bus_one_driver", drivers_ok(uo_out, uio_out), 8'h01);
    check("ee_bus_one_driver", drivers_ok(ee_uo, ee_uio), 8'h01);
    check("uio_oe", uio_oe, 8'hFF);
    check("ee_uio_oe", ee_oe, 8'hFF);
  endtask

  task automatic add(input bit ee, input bit rst, input logic [7:0] ui,
                     input logic [7:0] uo, input logic [7:0] uio);
    vec_t v;
    v.ee = ee; v.rst = rst; v.ui = ui; v.uo = uo; v.uio = uio;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input bit ee, input bit rst, input logic [7:0] ui);
    add(ee, rst, ui, 8'h06, 8'h20);
    add(ee, 1'b0, ui, 8'h01, 8'h40);
    add(ee, 1'b0, ui, 8'h18, 8'h60);
  endtask

  task automatic tick_check(input string name, input logic [7:0] uo, input logic [7:0] uio);
    @(negedge clk);
    #1;
    check({name, ".uo"}, uo_out, uo);
    check({name, ".uio"}, uio_out, uio);
    check_inv();
  endtask

  initial begin
    // Main instance, EARLY_END=0: LDA, SUB, ADD, OUT (opcode changed in T5), NOP.
    add_fetch(0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h24, 8'h80);
    add(0, 0, 8'h00, 8'h48, 8'hA0);
    add(0, 0, 8'h00, 8'h00, 8'hC0);
    add_fetch(0, 0, 8'h02);
    add(0, 0, 8'h02, 8'h24, 8'h80);
    add(0, 0, 8'h02, 8'h08, 8'hA4);
    add(0, 0, 8'h02, 8'h40, 8'hC3);
    add_fetch(0, 0, 8'h01);
    add(0, 0, 8'h01, 8'h24, 8'h80);
    add(0, 0, 8'h01, 8'h08, 8'hA4);
    add(0, 0, 8'h01, 8'h40, 8'hC2);
    add_fetch(0, 0, 8'h0E);
    add(0, 0, 8'h0E, 8'h80, 8'h88);
    add(0, 0, 8'h01, 8'h00, 8'hA0);
    add(0, 0, 8'h01, 8'h00, 8'hC0);
    add_fetch(0, 0, 8'h07);
    add(0, 0, 8'h07, 8'h00, 8'h80);
    add(0, 0, 8'h07, 8'h00, 8'hA0);
    add(0, 0, 8'h07, 8'h00, 8'hC0);
    // EARLY_END=1 instance: LDA (5 states), OUT (4), ADD (6), NOP (4), back to T1.
    add_fetch(1, 1, 8'h00);
    add(1, 0, 8'h00, 8'h24, 8'h80);
    add(1, 0, 8'h00, 8'h48, 8'hA0);
    add_fetch(1, 0, 8'h0E);
    add(1, 0, 8'h0E, 8'h80, 8'h88);
    add_fetch(1, 0, 8'h01);
    add(1, 0, 8'h01, 8'h24, 8'h80);
    add(1, 0, 8'h01, 8'h08, 8'hA4);
    add(1, 0, 8'h01, 8'h40, 8'hC2);
    add_fetch(1, 0, 8'h07);
    add(1, 0, 8'h07, 8'h00, 8'h80);
    add(1, 0, 8'h00, 8'h06, 8'h20);

    ui_in = 8'h00;
    ee_ui = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.uo", uo_out, 8'h06);
    check("reset.uio", uio_out, 8'h20);
    check_inv();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("vec%0d.rst_uo", i), vecs[i].ee ? ee_uo : uo_out, 8'h06);
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (vecs[i].ee) ee_ui = vecs[i].ui;
      else            ui_in = vecs[i].ui;
      #1;
      check($sformatf("vec%0d.uo", i), vecs[i].ee ? ee_uo : uo_out, vecs[i].uo);
      check($sformatf("vec%0d.uio", i), vecs[i].ee ? ee_uio : uio_out, vecs[i].uio);
      check_inv();
      @(negedge clk);
    end

    // HLT: T4 all zero, then HALT held for 20 clks despite step activity.
    rst_n = 1'b0;
    ui_in = 8'h0F;
    @(negedge clk);
    rst_n = 1'b1;
    tick_check("hlt.t2", 8'h01, 8'h40);
    tick_check("hlt.t3", 8'h18, 8'h60);
    tick_check("hlt.t4", 8'h00, 8'h80);
    tick_check("hlt.enter", 8'h00, 8'h10);
    for (int k = 0; k < 20; k++) begin
      ui_in = {2'b00, k[0], 1'b1, 4'h0};
      tick_check($sformatf("hlt.hold%0d", k), 8'h00, 8'h10);
    end
    ui_in = 8'h00;
    #1;
    rst_n = 1'b0;
    #1;
    check("hlt.async_rst.uo", uo_out, 8'h06);
    check("hlt.async_rst.uio", uio_out, 8'h20);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of SUB T5 returns to T1 without waiting for an edge.
    ui_in = 8'h02;
    repeat (3) @(negedge clk);
    tick_check("mid.t5", 8'h08, 8'hA4);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.rst.uo", uo_out, 8'h06);
    check("mid.rst.uio", uio_out, 8'h20);
    @(negedge clk);
    ui_in = 8'h00;
    rst_n = 1'b1;

`ifdef SAP1_STEP_MODE_EN
    rst_n = 1'b0;
    ui_in = 8'h10;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick_check($sformatf("step.freeze%0d", k), 8'h06, 8'h20);
    ui_in = 8'h30;
    for (int k = 1; k <= SYNC + 1; k++) begin
      if (k == SYNC + 1) tick_check($sformatf("step.edge%0d", k), 8'h01, 8'h40);
      else               tick_check($sformatf("step.edge%0d", k), 8'h06, 8'h20);
    end
    for (int k = 0; k < 5; k++) tick_check($sformatf("step.after%0d", k), 8'h01, 8'h40);
    ui_in = 8'h00;
`else
    ui_in = 8'h30;
    tick_check("nostep.t2", 8'h01, 8'h40);
    tick_check("nostep.t3", 8'h18, 8'h60);
    ui_in = 8'h00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
